// File: rtl/seg7_scan_pkg.sv
// Shared constants for the two-digit 7-segment scan display:
// active-low segment encodings and the digit-enable patterns.
package seg7_scan_pkg;

   // Active-low segment patterns for digits 0..9, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_LUT [10] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
      7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };

   // All segments dark
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Active-low digit enables: an[0] = units, an[1] = tens
   localparam logic [1:0] AN_UNITS = 2'b10;
   localparam logic [1:0] AN_TENS  = 2'b01;
   localparam logic [1:0] AN_OFF   = 2'b11;

endpackage : seg7_scan_pkg

// File: rtl/seg7_dec.sv
// Combinational decimal digit to active-low 7-segment pattern.
// Codes 10..15 are not decimal digits and produce a dark digit.
module seg7_dec
   import seg7_scan_pkg::*;
(
   input  logic [3:0] digit_i,
   output logic [6:0] seg_o
);

   // Table lookup for 0..9, blank for anything else
   always_comb begin
      seg_o = SEG_BLANK;
      if (digit_i <= 4'd9) begin
         seg_o = SEG_LUT[digit_i];
      end
   end

endmodule : seg7_dec

// File: rtl/seg7_scan.sv
// Two-digit multiplexed 7-segment display for a 0..15 count.
// The count is captured once per frame (at the end of the tens slot) so a
// frame never shows two different values; outputs are registered so the
// digit enables never glitch between slots.
module seg7_scan
   import seg7_scan_pkg::*;
#(
   parameter int unsigned DIV      = 50000,
   parameter bit          BLANK_LZ = 1'b1
)
(
   input  logic       clk,
   input  logic       rs,
   input  logic [3:0] q,
   output logic [6:0] seg,
   output logic [1:0] an
);

   localparam int unsigned      PRE_W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

   logic [PRE_W-1:0] pre_q, pre_d;
   logic             sel_q, sel_d;
   logic [3:0]       cap_q, cap_d;
   logic [6:0]       seg_q, seg_d;
   logic [1:0]       an_q,  an_d;

   logic             wrap;
   logic             tens;
   logic [3:0]       units;
   logic [6:0]       units_seg;

   // Prescaler wrap, slot toggle and once-per-frame capture of the count
   always_comb begin
      wrap  = (pre_q == PRE_LAST);
      pre_d = wrap ? '0 : pre_q + PRE_W'(1);
      sel_d = wrap ? ~sel_q : sel_q;
      cap_d = (wrap && sel_q) ? q : cap_q;
   end

   // Decimal split of the captured value (0..15 -> tens 0/1, units 0..9)
   always_comb begin
      tens  = (cap_q >= 4'd10);
      units = tens ? (cap_q - 4'd10) : cap_q;
   end

   seg7_dec u_dec (
      .digit_i (units),
      .seg_o   (units_seg)
   );

   // Next digit enable / segment pattern for the slot currently selected
   always_comb begin
      an_d  = AN_UNITS;
      seg_d = units_seg;
      if (sel_q) begin
         if (tens) begin
            an_d  = AN_TENS;
            seg_d = SEG_LUT[1];
         end else if (BLANK_LZ) begin
            an_d  = AN_OFF;
            seg_d = SEG_BLANK;
         end else begin
            an_d  = AN_TENS;
            seg_d = SEG_LUT[0];
         end
      end
   end

   // State and output registers; reset restarts the frame dark, showing 0 next
   always_ff @(posedge clk) begin
      if (rs) begin
         pre_q <= '0;
         sel_q <= 1'b0;
         cap_q <= 4'd0;
         an_q  <= AN_OFF;
         seg_q <= SEG_BLANK;
      end else begin
         pre_q <= pre_d;
         sel_q <= sel_d;
         cap_q <= cap_d;
         an_q  <= an_d;
         seg_q <= seg_d;
      end
   end

   assign seg = seg_q;
   assign an  = an_q;

endmodule : seg7_scan

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan with DIV = 4. Two instances share clock, reset and
// count: one blanks the leading zero, the other shows it. A table of
// segments (inputs held for n edges, expected outputs after each edge)
// walks through reset, capture, slot lengths, q changes between captures
// and a mid-slot reset.
module tb_seg7_scan;

   logic       clk = 1'b0;
   logic       rs;
   logic [3:0] q;
   logic [6:0] seg1, seg0;
   logic [1:0] an1,  an0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seg7_scan #(.DIV(4), .BLANK_LZ(1'b1)) dut_blank (
      .clk (clk),
      .rs  (rs),
      .q   (q),
      .seg (seg1),
      .an  (an1)
   );

   seg7_scan #(.DIV(4), .BLANK_LZ(1'b0)) dut_zero (
      .clk (clk),
      .rs  (rs),
      .q   (q),
      .seg (seg0),
      .an  (an0)
   );

   typedef struct {
      logic       rs;
      logic [3:0] q;
      int         n;
      logic [1:0] an1;
      logic [6:0] seg1;
      logic [1:0] an0;
      logic [6:0] seg0;
   } vec_t;

   localparam int NV = 18;
   vec_t tbl [NV];

   task automatic chk(input string name, input int vi, input int cyc,
                      input logic [6:0] act, input logic [6:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s vec %0d cyc %0d got %h want %h", name, vi, cyc, act, exp);
      end
   endtask

   initial begin
      // rs, q, edges, an/seg (blanking), an/seg (leading zero shown)
      tbl[0]  = '{1'b1, 4'd15, 3, 2'b11, 7'h7F, 2'b11, 7'h7F}; // reset held
      tbl[1]  = '{1'b0, 4'd7,  4, 2'b10, 7'h40, 2'b10, 7'h40}; // units shows 0
      tbl[2]  = '{1'b0, 4'd7,  4, 2'b11, 7'h7F, 2'b01, 7'h40}; // tens, capture 7
      tbl[3]  = '{1'b0, 4'd7,  4, 2'b10, 7'h78, 2'b10, 7'h78}; // units 7
      tbl[4]  = '{1'b0, 4'd13, 4, 2'b11, 7'h7F, 2'b01, 7'h40}; // tens, capture 13
      tbl[5]  = '{1'b0, 4'd5,  4, 2'b10, 7'h30, 2'b10, 7'h30}; // units 3 of 13
      tbl[6]  = '{1'b0, 4'd5,  4, 2'b01, 7'h79, 2'b01, 7'h79}; // tens 1, capture 5
      tbl[7]  = '{1'b0, 4'd5,  1, 2'b10, 7'h12, 2'b10, 7'h12}; // units 5
      tbl[8]  = '{1'b0, 4'd9,  3, 2'b10, 7'h12, 2'b10, 7'h12}; // q->9, still 5
      tbl[9]  = '{1'b0, 4'd9,  4, 2'b11, 7'h7F, 2'b01, 7'h40}; // tens, capture 9
      tbl[10] = '{1'b0, 4'd9,  4, 2'b10, 7'h10, 2'b10, 7'h10}; // units 9
      tbl[11] = '{1'b0, 4'd13, 4, 2'b11, 7'h7F, 2'b01, 7'h40}; // tens, capture 13
      tbl[12] = '{1'b0, 4'd13, 4, 2'b10, 7'h30, 2'b10, 7'h30}; // units 3
      tbl[13] = '{1'b0, 4'd13, 1, 2'b01, 7'h79, 2'b01, 7'h79}; // tens slot starts
      tbl[14] = '{1'b1, 4'd13, 1, 2'b11, 7'h7F, 2'b11, 7'h7F}; // mid-slot reset
      tbl[15] = '{1'b0, 4'd13, 4, 2'b10, 7'h40, 2'b10, 7'h40}; // full units slot, 0
      tbl[16] = '{1'b0, 4'd13, 4, 2'b11, 7'h7F, 2'b01, 7'h40}; // tens, capture 13
      tbl[17] = '{1'b0, 4'd13, 1, 2'b10, 7'h30, 2'b10, 7'h30}; // new value next edge

      rs = 1'b1;
      q  = 4'd15;

      for (int v = 0; v < NV; v++) begin
         for (int c = 0; c < tbl[v].n; c++) begin
            @(negedge clk);
            rs = tbl[v].rs;
            q  = tbl[v].q;
            @(posedge clk);
            #1;
            chk("an_blank",  v, c, {5'd0, an1}, {5'd0, tbl[v].an1});
            chk("seg_blank", v, c, seg1,        tbl[v].seg1);
            chk("an_zero",   v, c, {5'd0, an0}, {5'd0, tbl[v].an0});
            chk("seg_zero",  v, c, seg0,        tbl[v].seg0);
            // never two digits lit together
            chk("an_onehot", v, c, {6'd0, (an1 == 2'b00) || (an0 == 2'b00)}, 7'd0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_seg7_scan
